// File: rtl/matrix_generate_kxk.sv
// KxK sliding-window generator for streaming grey images.
// K-1 cascaded line buffers, two-stage pipeline, zero/replicate border fill.
module matrix_generate_kxk #(
  parameter int DATA_WIDTH = 8,
  parameter int KSIZE      = 3,
  parameter int MAX_WIDTH  = 1024,
  localparam int CW = $clog2(MAX_WIDTH + 1),
  localparam int DW = DATA_WIDTH,
  localparam int K  = KSIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CW-1:0]     cfg_img_width,
  input  logic              cfg_border_mode,
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic              per_frame_clken,
  input  logic [DW-1:0]     per_img_y,
  output logic              matrix_frame_vsync,
  output logic              matrix_frame_href,
  output logic              matrix_frame_clken,
  output logic [K*K*DW-1:0] matrix_data,
  output logic              matrix_win_valid,
  output logic [CW-1:0]     matrix_row,
  output logic [CW-1:0]     matrix_col,
  output logic              line_overrun
);

  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  if (!(KSIZE == 3 || KSIZE == 5)) begin : g_bad_ksize
    $error("KSIZE must be 3 or 5");
  end

  typedef enum logic {IDLE, FRAME} state_t;

  state_t state_q, state_d;

  logic          vs_q, hr_q, mode_q;
  logic [CW-1:0] r_q, c_q, width_q;
  logic          rise, fall, in_frame, beat, over, wr;
  logic [CW-1:0] cur_r, cur_c, cur_w;
  logic          cur_m;
  logic [AW-1:0] addr;

  logic [DW-1:0] mem [K-1][MAX_WIDTH];
  logic [DW-1:0] rd_s1 [K-1];
  logic [DW-1:0] pix_s1;
  logic [CW-1:0] r_s1, c_s1;
  logic          vs_s1, hr_s1, ck_s1;
  logic          frame_s1, rise_s1, beat_s1, over_s1, mode_s1;

  logic [DW-1:0]     v [K];
  logic [DW-1:0]     row0;
  logic [K*K*DW-1:0] taps_q, tap_nx;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  assign rise     = per_frame_vsync & ~vs_q;
  assign fall     = ~per_frame_vsync & vs_q;
  assign in_frame = (state_q == FRAME) | rise;
  assign beat     = in_frame & per_frame_href & per_frame_clken;
  assign cur_r    = rise ? '0 : r_q;
  assign cur_c    = rise ? '0 : c_q;
  assign cur_w    = rise ? cfg_img_width : width_q;
  assign cur_m    = rise ? cfg_border_mode : mode_q;
  assign over     = beat & (cur_c >= cur_w);
  assign wr       = beat & ~over;
  assign addr     = cur_c[AW-1:0];

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rise) state_d = FRAME;
      FRAME:   if (fall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // vs_q resets high so a frame still in progress is not re-entered
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q    <= 1'b1;
      hr_q    <= 1'b0;
      mode_q  <= 1'b0;
      width_q <= '0;
      r_q     <= '0;
      c_q     <= '0;
    end else begin
      vs_q <= per_frame_vsync;
      hr_q <= per_frame_href;
      if (rise) begin
        width_q <= cfg_img_width;
        mode_q  <= cfg_border_mode;
        r_q     <= '0;
        c_q     <= beat ? CW'(1) : '0;
      end else if (state_q == FRAME) begin
        if (beat) begin
          c_q <= sat_inc(c_q);
        end else if (hr_q && !per_frame_href) begin
          c_q <= '0;
          r_q <= sat_inc(r_q);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[0][addr] <= per_img_y;
      for (int k = 1; k < K-1; k++) mem[k][addr] <= mem[k-1][addr];
      for (int k = 0; k < K-1; k++) rd_s1[k] <= mem[k][addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_s1    <= 1'b0;
      hr_s1    <= 1'b0;
      ck_s1    <= 1'b0;
      frame_s1 <= 1'b0;
      rise_s1  <= 1'b0;
      beat_s1  <= 1'b0;
      over_s1  <= 1'b0;
      mode_s1  <= 1'b0;
      pix_s1   <= '0;
      r_s1     <= '0;
      c_s1     <= '0;
    end else begin
      vs_s1    <= per_frame_vsync;
      hr_s1    <= per_frame_href;
      ck_s1    <= per_frame_clken;
      frame_s1 <= in_frame;
      rise_s1  <= rise;
      beat_s1  <= wr;
      over_s1  <= over;
      mode_s1  <= cur_m;
      if (wr) begin
        pix_s1 <= per_img_y;
        r_s1   <= cur_r;
        c_s1   <= cur_c;
      end
    end
  end

  // column vector: entry i comes from row r-(K-1-i), clamped or zeroed above row 0
  always_comb begin
    row0 = pix_s1;
    for (int k = 0; k < K-1; k++)
      if (int'(r_s1) == k + 1) row0 = rd_s1[k];
    v[K-1] = pix_s1;
    for (int i = 0; i < K-1; i++) v[i] = rd_s1[K-2-i];
    for (int i = 0; i < K; i++)
      if (K - 1 - i > int'(r_s1)) v[i] = mode_s1 ? row0 : '0;
  end

  always_comb begin
    tap_nx = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        if (j == K-1)
          tap_nx[(i*K+j)*DW +: DW] = v[i];
        else if (c_s1 != '0)
          tap_nx[(i*K+j)*DW +: DW] = taps_q[(i*K+j+1)*DW +: DW];
        else if (mode_s1)
          tap_nx[(i*K+j)*DW +: DW] = v[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      matrix_frame_vsync <= 1'b0;
      matrix_frame_href  <= 1'b0;
      matrix_frame_clken <= 1'b0;
      matrix_win_valid   <= 1'b0;
      matrix_row         <= '0;
      matrix_col         <= '0;
      line_overrun       <= 1'b0;
      taps_q             <= '0;
    end else begin
      matrix_frame_vsync <= vs_s1;
      matrix_frame_href  <= hr_s1;
      matrix_frame_clken <= ck_s1;
      matrix_win_valid   <= beat_s1 && int'(r_s1) >= K-1 && int'(c_s1) >= K-1;
      if (rise_s1)      line_overrun <= 1'b0;
      else if (over_s1) line_overrun <= 1'b1;
      if (beat_s1) begin
        taps_q     <= tap_nx;
        matrix_row <= r_s1;
        matrix_col <= c_s1;
      end else if (!hr_s1 || !frame_s1) begin
        taps_q <= '0;
      end
    end
  end

  assign matrix_data = taps_q;

endmodule
